// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory load/store unit: access modes,
// FSM state encoding, the latched request record and the alignment rule.
package data_mem_pkg;

   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_WORD = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   localparam logic [1:0] ST_CLEAR = 2'b00;
   localparam logic [1:0] ST_IDLE  = 2'b01;
   localparam logic [1:0] ST_WAIT  = 2'b10;

   typedef struct packed {
      logic        we;
      logic [1:0]  mode;
      logic        uns;
      logic [31:0] wdata;
   } ls_req_t;

   // An access is rejected when its lane offset does not fit its size, or the mode is reserved.
   function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] lane);
      logic bad;
      case (mode)
         MODE_BYTE: bad = 1'b0;
         MODE_HALF: bad = lane[0];
         MODE_WORD: bad = (lane != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ls_align.sv
// Lane alignment for loads and stores: extracts/extends the load value and
// builds the merged store word plus byte enables for one RAM word.
module ls_align
   import data_mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [1:0]  mode_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o,
   output logic [3:0]  be_o,
   output logic        misalign_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] wrep;

   // Select the addressed lane, extend it, and merge store data into the untouched lanes.
   always_comb begin
      misalign_o = misaligned(mode_i, lane_i);
      byte_v     = word_i[{lane_i, 3'b000} +: 8];
      half_v     = lane_i[1] ? word_i[31:16] : word_i[15:0];
      load_o     = word_i;
      be_o       = 4'b0000;
      wrep       = wdata_i;
      case (mode_i)
         MODE_BYTE: begin
            load_o = {{24{~uns_i & byte_v[7]}}, byte_v};
            be_o   = 4'b0001 << lane_i;
            wrep   = {4{wdata_i[7:0]}};
         end
         MODE_HALF: begin
            load_o = {{16{~uns_i & half_v[15]}}, half_v};
            be_o   = lane_i[1] ? 4'b1100 : 4'b0011;
            wrep   = {2{wdata_i[15:0]}};
         end
         MODE_WORD: begin
            load_o = word_i;
            be_o   = 4'b1111;
         end
         default: begin
            load_o = word_i;
            be_o   = 4'b0000;
         end
      endcase
      if (misalign_o) be_o = 4'b0000;
      store_o = word_i;
      for (int i = 0; i < 4; i++) begin
         if (be_o[i]) store_o[8*i +: 8] = wrep[8*i +: 8];
      end
   end

endmodule

// File: rtl/data_ram_ls.sv
// Data memory with load/store unit for the CPU datapath.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_CLEAR | post-reset sweep, one zero word per cycle, requests ignored
//  ST_IDLE  | ready; with no wait states an accepted access completes here
//  ST_WAIT  | counting wait states for the latched access
module data_ram_ls
   import data_mem_pkg::*;
#(
   parameter int ADDR_WIDTH     = 12,
   parameter int WAIT_CYCLES    = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [1:0]            mode,
   input  logic                  uns,
   input  logic [31:0]           wdata,
   output logic                  ready,
   output logic                  done,
   output logic [31:0]           rdata,
   output logic                  err,
   output logic                  busy
);

   localparam int IW    = ADDR_WIDTH - 2;
   localparam int DEPTH = 2 ** IW;
   localparam logic [1:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   logic [31:0] mem [DEPTH];

   logic [1:0]            state_q, state_d;
   logic [IW-1:0]         clr_cnt_q, clr_cnt_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic                  hold_q, hold_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;
   ls_req_t               lreq_q, lreq_d;
   logic [ADDR_WIDTH-1:0] laddr_q, laddr_d;

   logic                  accept;
   logic                  complete;
   logic                  use_inputs;
   ls_req_t               op;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [IW-1:0]         op_idx;
   logic [31:0]           rd_word;
   logic [31:0]           load_val;
   logic [31:0]           store_word;
   logic [3:0]            be;
   logic                  misalign;
   logic                  clear_wr;
   logic                  store_wr;

   // hold_q keeps ready low for the first cycle after reset, even when no sweep runs.
   assign ready  = (state_q == ST_IDLE) && !hold_q;
   assign busy   = (state_q == ST_CLEAR);
   assign done   = done_q;
   assign err    = err_q;
   assign rdata  = rdata_q;
   assign accept = req && ready;

   // With zero wait states the access is performed from the live inputs on the accept edge.
   assign use_inputs = (state_q == ST_IDLE);
   assign op         = use_inputs ? ls_req_t'{we: we, mode: mode, uns: uns, wdata: wdata} : lreq_q;
   assign op_addr    = use_inputs ? addr : laddr_q;
   assign op_idx     = op_addr[ADDR_WIDTH-1:2];
   assign rd_word    = mem[op_idx];

   assign complete = !clr &&
                     (((state_q == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_WAIT) && (wcnt_q == 4'd1)));
   assign clear_wr = !clr && (state_q == ST_CLEAR);
   assign store_wr = complete && op.we && !misalign && (be != 4'b0000);

   ls_align u_align (
      .word_i     (rd_word),
      .lane_i     (op_addr[1:0]),
      .mode_i     (op.mode),
      .uns_i      (op.uns),
      .wdata_i    (op.wdata),
      .load_o     (load_val),
      .store_o    (store_word),
      .be_o       (be),
      .misalign_o (misalign)
   );

   // Next-state logic: clear sweep, request latch, wait-state countdown and completion results.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      wcnt_d    = wcnt_q;
      hold_d    = 1'b0;
      lreq_d    = lreq_q;
      laddr_d   = laddr_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {IW{1'b1}}) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (accept) begin
               lreq_d  = op;
               laddr_d = addr;
               if (WAIT_CYCLES != 0) begin
                  state_d = ST_WAIT;
                  wcnt_d  = 4'(WAIT_CYCLES);
               end
            end
         end
         ST_WAIT: begin
            wcnt_d = wcnt_q - 1'b1;
            if (wcnt_q == 4'd1) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (complete) begin
         done_d = 1'b1;
         err_d  = misalign;
         if (!op.we && !misalign) rdata_d = load_val;
      end
   end

   // Control registers; reset aborts any in-flight access.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_RESET;
         clr_cnt_q <= '0;
         wcnt_q    <= '0;
         hold_q    <= 1'b1;
         lreq_q    <= '0;
         laddr_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         wcnt_q    <= wcnt_d;
         hold_q    <= hold_d;
         lreq_q    <= lreq_d;
         laddr_q   <= laddr_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   // Memory array write port, shared by the clear sweep and completed stores.
   always_ff @(posedge clk) begin
      if (clear_wr) mem[clr_cnt_q] <= '0;
      else if (store_wr) mem[op_idx] <= store_word;
   end

endmodule
